// File: rtl/dec_link_pkg.sv
// Shared types for the encoded link receiver: 3-bit line codes and their 8-line one-hot form.
package dec_link_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINES-1:0]  onehot_t;

    function automatic onehot_t onehot_of(code_t code);
        onehot_t oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dec_link_fifo.sv
// Small synchronous FIFO of line codes; pointers wrap naturally because DEPTH is a power of two.
module dec_link_fifo
    import dec_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  code_t                      push_data,
    input  logic                       pop,
    output code_t                      head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    code_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dec_link_rx.sv
// Receive stage of the encoded link: buffers 3-bit codes, expands them to one-hot, tracks dropped words.
// Optional macro DEC_PARITY_EN adds an even-parity input; failing words are dropped and counted.
module dec_link_rx
    import dec_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  code_t            in_code,
`ifdef DEC_PARITY_EN
    input  logic             in_parity,
`endif
    output logic             out_valid,
    output code_t            out_code,
    output onehot_t          out_onehot,
    input  logic             out_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             clr
);

    code_t                  fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   parity_ok;
    logic                   pop;
    logic                   push;
    logic                   ovf_drop;
    logic                   word_drop;

`ifdef DEC_PARITY_EN
    assign parity_ok = ~^{in_code, in_parity};
`else
    assign parity_ok = 1'b1;
`endif

    assign out_valid  = (fifo_count != '0);
    assign out_code   = out_valid ? fifo_head : '0;
    assign out_onehot = out_valid ? onehot_of(fifo_head) : '0;

    // A simultaneous pop frees the slot, so a full FIFO still accepts in that cycle.
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && parity_ok && (!fifo_full || pop);
    assign ovf_drop  = in_valid && parity_ok && fifo_full && !pop;
    assign word_drop = ovf_drop || (in_valid && !parity_ok);

    dec_link_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_code),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // clr wins over a same-cycle drop; the counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ovf_drop) begin
                ovf <= 1'b1;
            end
            if (word_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_link_rx.sv
// Self-checking bench for dec_link_rx: queue-based reference model plus directed literal checks.
module tb_dec_link_rx;
    import dec_link_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    code_t            in_code = '0;
`ifdef DEC_PARITY_EN
    logic             in_parity = 1'b0;
`endif
    logic             out_valid;
    code_t            out_code;
    onehot_t          out_onehot;
    logic             out_ready = 1'b0;
    logic             ovf;
    logic [CNT_W-1:0] drop_cnt;
    logic             clr = 1'b0;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    int q[$];
    bit m_ovf;
    int m_cnt;
    bit m_pop;
    bit m_full;
    bit m_par_ok;
    bit m_overflow;
    bit m_bad;

    logic [7:0] oh_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    dec_link_rx #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_code    (in_code),
`ifdef DEC_PARITY_EN
        .in_parity  (in_parity),
`endif
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt),
        .clr        (clr)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit v, input int code, input bit rdy);
        in_valid  = v;
        in_code   = code_t'(code);
`ifdef DEC_PARITY_EN
        in_parity = ^code_t'(code);
`endif
        out_ready = rdy;
        tick();
    endtask

    // Reference: the FIFO is a plain queue; every word is either queued, popped or counted as lost.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            m_pop    = (q.size() > 0) && out_ready;
            m_full   = (q.size() == DEPTH);
            m_par_ok = 1'b1;
`ifdef DEC_PARITY_EN
            m_par_ok = (($countones({in_code, in_parity}) % 2) == 0);
`endif
            m_overflow = in_valid && m_par_ok && m_full && !m_pop;
            m_bad      = in_valid && !m_par_ok;
            if (m_pop) void'(q.pop_front());
            if (in_valid && m_par_ok && !m_overflow) q.push_back(int'(in_code));
            if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end else begin
                if (m_overflow) m_ovf = 1'b1;
                if ((m_overflow || m_bad) && m_cnt < SAT) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("out_valid",  out_valid,  (q.size() != 0));
            check_output("out_code",   out_code,   (q.size() != 0) ? q[0] : 0);
            check_output("out_onehot", out_onehot, (q.size() != 0) ? (1 << q[0]) : 0);
            check_output("ovf",        ovf,        m_ovf);
            check_output("drop_cnt",   drop_cnt,   m_cnt);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_en = 1'b1;
        check_output("reset_valid",    out_valid,  0);
        check_output("reset_code",     out_code,   0);
        check_output("reset_onehot",   out_onehot, 0);
        check_output("reset_ovf",      ovf,        0);
        check_output("reset_drop_cnt", drop_cnt,   0);

        apply_stimulus(1, 5, 0);
        check_output("single_valid",  out_valid,  1);
        check_output("single_code",   out_code,   5);
        check_output("single_onehot", out_onehot, 8'h20);
        apply_stimulus(0, 0, 1);
        check_output("popped_valid",  out_valid,  0);
        check_output("popped_onehot", out_onehot, 8'h00);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, i, 1);
            check_output("stream_onehot", out_onehot, oh_seq[i]);
        end
        apply_stimulus(0, 0, 1);
        check_output("stream_drop_cnt", drop_cnt,  0);
        check_output("stream_drained",  out_valid, 0);

        for (int i = 0; i < 6; i++) apply_stimulus(1, i + 1, 0);
        check_output("overflow_ovf",      ovf,      1);
        check_output("overflow_drop_cnt", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            check_output("drain_order", out_code, i + 1);
            apply_stimulus(0, 0, 1);
        end
        check_output("drain_empty", out_valid, 0);

        clr = 1'b1;
        apply_stimulus(0, 0, 0);
        clr = 1'b0;
        check_output("clr_ovf",      ovf,      0);
        check_output("clr_drop_cnt", drop_cnt, 0);

        for (int i = 0; i < 4; i++) apply_stimulus(1, i, 0);
        apply_stimulus(1, 7, 1);
        check_output("full_pop_drop_cnt", drop_cnt, 0);
        check_output("full_pop_ovf",      ovf,      0);
        check_output("full_pop_head",     out_code, 1);
        apply_stimulus(1, 6, 0);
        check_output("still_full_drop", drop_cnt, 1);

        repeat (300) apply_stimulus(1, $urandom_range(0, 7), 0);
        check_output("saturated_drop_cnt", drop_cnt, 255);
        check_output("saturated_ovf",      ovf,      1);

        clr = 1'b1;
        apply_stimulus(1, 1, 0);
        clr = 1'b0;
        check_output("clr_vs_drop_ovf",      ovf,      0);
        check_output("clr_vs_drop_drop_cnt", drop_cnt, 0);

        repeat (4) apply_stimulus(0, 0, 1);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 4, 0);
        rst = 1'b1;
        apply_stimulus(0, 0, 0);
        rst = 1'b0;
        check_output("rst_mid_valid",  out_valid,  0);
        check_output("rst_mid_onehot", out_onehot, 0);
        apply_stimulus(1, 2, 0);
        check_output("after_rst_onehot", out_onehot, 8'h04);
        apply_stimulus(0, 0, 1);

`ifdef DEC_PARITY_EN
        in_valid  = 1'b1;
        in_code   = 3'd3;
        in_parity = 1'b0;
        out_ready = 1'b0;
        tick();
        check_output("parity_good_code", out_code, 3);
        check_output("parity_good_cnt",  drop_cnt, 0);
        in_parity = 1'b1;
        tick();
        check_output("parity_bad_cnt", drop_cnt, 1);
        check_output("parity_bad_ovf", ovf,      0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_output("parity_bad_not_queued", out_valid, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 249) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 99) < 70);
            in_code   = code_t'($urandom_range(0, 7));
`ifdef DEC_PARITY_EN
            in_parity = (^in_code) ^ ($urandom_range(0, 7) == 0);
`endif
            out_ready = ($urandom_range(0, 99) < 45);
            tick();
        end

        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        tick();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
